fu_wb_arbiter: RTL



---
 rtl/fu_wb_arbiter_pkg.sv | 26 ++
 rtl/fu_wb_arbiter_if.sv | 45 ++++
 rtl/fu_wb_arbiter_rr_select.sv | 45 ++++
 rtl/fu_wb_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types for the execute-stage writeback collector.
// Entry layout and widths used by buffers, selector and ports.
package fu_wb_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        xlen_t cause;
        xlen_t tval;
        logic  valid;
    } exception_t;

    typedef struct packed {
        xlen_t                     result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t                ex;
    } wb_entry_t;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// Source-side handshake and writeback bus of the collector.
// master = FUs plus scoreboard, slave = the arbiter.
interface fu_wb_arbiter_if
    import fu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NrSrc     = 4,
    parameter int unsigned NrWbPorts = 2
);

    logic [NrSrc-1:0]                         src_valid_i;
    logic [NrSrc-1:0]                         src_ready_o;
    logic [NrSrc-1:0][XLEN-1:0]               src_result_i;
    logic [NrSrc-1:0][TRANS_ID_BITS-1:0]      src_trans_id_i;
    exception_t [NrSrc-1:0]                   src_exception_i;

    logic [NrWbPorts-1:0]                     wb_valid_o;
    logic [NrWbPorts-1:0][XLEN-1:0]           wb_result_o;
    logic [NrWbPorts-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_o;
    exception_t [NrWbPorts-1:0]               wb_exception_o;

    modport master (
        output src_valid_i,
        output src_result_i,
        output src_trans_id_i,
        output src_exception_i,
        input  src_ready_o,
        input  wb_valid_o,
        input  wb_result_o,
        input  wb_trans_id_o,
        input  wb_exception_o
    );

    modport slave (
        input  src_valid_i,
        input  src_result_i,
        input  src_trans_id_i,
        input  src_exception_i,
        output src_ready_o,
        output wb_valid_o,
        output wb_result_o,
        output wb_trans_id_o,
        output wb_exception_o
    );

endinterface

// File: rtl/fu_wb_arbiter_rr_select.sv
// Round-robin selector: first NrWbPorts non-empty sources from rr.
// Purely combinational; the i-th hit in scan order goes to port i.
module fu_wb_rr_select
    import fu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NrSrc     = 4,
    parameter int unsigned NrWbPorts = 2,
    localparam int unsigned IdxW     = idx_width(NrSrc)
) (
    input  logic [NrSrc-1:0]                nonempty,
    input  logic [IdxW-1:0]                 rr,
    output logic [NrWbPorts-1:0][IdxW-1:0]  gnt_idx,
    output logic [NrWbPorts-1:0]            gnt_valid,
    output logic [IdxW-1:0]                 rr_next
);

    always_comb begin
        int unsigned n;
        int unsigned k;
        logic [IdxW-1:0] ki;
        gnt_idx   = '0;
        gnt_valid = '0;
        rr_next   = rr;
        n         = 0;
        k         = 0;
        ki        = '0;
        for (int unsigned j = 0; j < NrSrc; j++) begin
            k = 32'(rr) + j;
            if (k >= NrSrc) k = k - NrSrc;
            ki = IdxW'(k);
            if (nonempty[ki] && (n < NrWbPorts)) begin
                for (int unsigned p = 0; p < NrWbPorts; p++) begin
                    if (p == n) begin
                        gnt_valid[p] = 1'b1;
                        gnt_idx[p]   = ki;
                    end
                end
                // pointer lands just past the last source granted
                rr_next = (k + 1 == NrSrc) ? '0 : IdxW'(k + 1);
                n = n + 1;
            end
        end
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback collector: per-FU result FIFOs drained round-robin
// onto NrWbPorts scoreboard ports, one result per source per cycle.
module fu_wb_arbiter
    import fu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NrSrc     = 4,
    parameter int unsigned NrWbPorts = 2,
    parameter int unsigned Depth     = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    fu_wb_arbiter_if.slave  bus,
    output logic            idle_o
);

    localparam int unsigned IdxW = idx_width(NrSrc);
    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    logic [NrSrc-1:0]                nonempty;
    wb_entry_t [NrSrc-1:0]           heads;
    logic [IdxW-1:0]                 rr_q;
    logic [IdxW-1:0]                 rr_next;
    logic [NrWbPorts-1:0][IdxW-1:0]  gnt_idx;
    logic [NrWbPorts-1:0]            gnt_valid;

    fu_wb_rr_select #(
        .NrSrc     (NrSrc),
        .NrWbPorts (NrWbPorts)
    ) u_select (
        .nonempty  (nonempty),
        .rr        (rr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .rr_next   (rr_next)
    );

    for (genvar k = 0; k < NrSrc; k++) begin : g_src
        wb_entry_t mem_q [Depth];
        ptr_t      rd_q;
        ptr_t      wr_q;
        cnt_t      cnt_q;
        ptr_t      rd_nxt;
        ptr_t      wr_nxt;
        wb_entry_t din;
        logic      ready;
        logic      push;
        logic      pop;

        assign ready = (cnt_q < cnt_t'(Depth));
        assign push  = bus.src_valid_i[k] & ready;

        always_comb begin
            pop = 1'b0;
            for (int unsigned p = 0; p < NrWbPorts; p++) begin
                if (gnt_valid[p] && (gnt_idx[p] == IdxW'(k))) pop = 1'b1;
            end
        end

        assign din.result   = bus.src_result_i[k];
        assign din.trans_id = bus.src_trans_id_i[k];
        assign din.ex       = bus.src_exception_i[k];

        // wrap explicitly so a non-power-of-two Depth works
        assign rd_nxt = (rd_q == ptr_t'(Depth - 1)) ? '0 : rd_q + 1'b1;
        assign wr_nxt = (wr_q == ptr_t'(Depth - 1)) ? '0 : wr_q + 1'b1;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
                for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
            end else if (flush_i) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_q] <= din;
                    wr_q        <= wr_nxt;
                end
                if (pop) rd_q <= rd_nxt;
                if (push && !pop) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (pop && !push) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end

        assign nonempty[k]        = (cnt_q != '0);
        assign heads[k]           = mem_q[rd_q];
        assign bus.src_ready_o[k] = ready;
    end

    for (genvar p = 0; p < NrWbPorts; p++) begin : g_port
        wb_entry_t sel;

        assign sel = gnt_valid[p] ? heads[gnt_idx[p]] : '0;

        assign bus.wb_valid_o[p]     = gnt_valid[p];
        assign bus.wb_result_o[p]    = sel.result;
        assign bus.wb_trans_id_o[p]  = sel.trans_id;
        assign bus.wb_exception_o[p] = sel.ex;
    end

    // a flush keeps rr where it was; flush-cycle grants are void
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (!flush_i && (|gnt_valid)) begin
            rr_q <= rr_next;
        end
    end

    assign idle_o = ~|nonempty;

endmodule
